hazard_ctrl_mc: RTL and testbench
=================================

Name: hazard_ctrl_mc

Overview:
- Next-generation pipeline hazard controller for the 5-stage RV32 core.
- Generalised from the single-cycle hazard unit:
  - N source-operand checks with per-source valid masks and x0 exclusion.
  - Configurable load-use latency.
  - Multi-cycle instruction-memory and data-memory wait stalls.
  - A sticky fetch-kill state for redirects taken while a fetch is outstanding.
- Sits beside ID/EX; drives PC write-enable, IF/ID write/flush, ID/EX flush and a global pipe hold.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands checked in ID (1..3).
- LOAD_LAT, 1, load-use stall cycles (1..3).
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- br_ctrl  in  2  EX redirect select: 00 PC4, 01 branch, 10 jalr, 11 treated as redirect.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rd_addr  in  REG_AW  destination register of the EX instruction.
- src_addr  in  NUM_SRC*REG_AW  ID source addresses; source i at bits [i*REG_AW +: REG_AW].
- src_used  in  NUM_SRC  per-source valid mask.
- im_stall  in  1  instruction fetch not ready this cycle.
- dm_stall  in  1  data memory access not complete this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- instr_flush  out  1  load NOP into IF/ID.
- id_flush  out  1  load NOP into ID/EX.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- lu_stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  redirect events.
- mem_stall_cnt  out  CNT_W  dm_stall cycles.

Behaviour:
- State is registered; outputs are combinational from state and inputs.
- FSM states:
  - NORMAL.
  - LU_STALL, with down-counter lu_cnt of width clog2(LOAD_LAT+1).
  - KILL_FETCH.
- Reset (rst_n=0, asynchronous):
  - state=NORMAL, lu_cnt=0, counters=0.
  - Outputs forced to pc_write=0, ifid_write=0, instr_flush=1, id_flush=1, pipe_hold=0.
- Hazard match: asserted when ex_mem_read=1 and ex_rd_addr!=0 and, for some i, src_used[i]=1 and src_addr[i]==ex_rd_addr.
- Priority, highest first:
  - 1) dm_stall=1:
    - pipe_hold=1, pc_write=0, ifid_write=0, instr_flush=0, id_flush=0.
    - State and lu_cnt are frozen.
  - 2) redirect (br_ctrl!=00):
    - pc_write=1, ifid_write=1, instr_flush=1, id_flush=1.
    - An active LU_STALL is aborted and lu_cnt is cleared.
    - If im_stall=1 in the same cycle, next state is KILL_FETCH; otherwise NORMAL.
  - 3) In state KILL_FETCH:
    - instr_flush=1, ifid_write=1, pc_write=!im_stall.
    - Leaves for NORMAL on the first cycle im_stall=0; that returning stale instruction is still flushed.
  - 4) In state LU_STALL, or a hazard match while in NORMAL:
    - pc_write=0, ifid_write=0, instr_flush=0, id_flush=1.
    - On a new match in NORMAL with LOAD_LAT>1: load lu_cnt=LOAD_LAT-1 and go to LU_STALL.
    - In LU_STALL: decrement lu_cnt each cycle; return to NORMAL when lu_cnt reaches 1 at the decrement.
    - Total bubbles inserted = LOAD_LAT exactly.
  - 5) im_stall=1: pc_write=0, ifid_write=1, instr_flush=1, id_flush=0.
  - 6) Otherwise: pc_write=1, ifid_write=1, instr_flush=0, id_flush=0, pipe_hold=0.
- pipe_hold=0 except under rule 1.
- A hazard match concurrent with im_stall takes the load-use response (rule 4).

Optional Feature:
- HAZARD_PERF_EN defined:
  - Three counters, saturating at all-ones, clearing on reset.
  - lu_stall_cnt increments on each rule-4 cycle.
  - flush_cnt increments on each rule-2 cycle.
  - mem_stall_cnt increments on each rule-1 cycle.
- Undefined: the counter ports remain present and are tied to 0; no counter flops are inferred.

Decomposition:
- Package hazard_pkg:
  - br_ctrl_e enum (PC4=2'b00, PCB=2'b01, PCJR=2'b10).
  - hz_state_e enum (NORMAL, LU_STALL, KILL_FETCH).
  - Default REG_AW.
- Sub-module hazard_match: parametrised NUM_SRC/REG_AW comparator producing the hazard-match bit. It is purely combinational and reused by the forwarding unit.

Test Plan:
- LOAD_LAT=1: ex_mem_read=1, ex_rd=5, src_addr[0]=5, src_used=01 -> exactly 1 cycle of pc_write=0, ifid_write=0, id_flush=1, then normal.
- LOAD_LAT=3: the same load-use -> 3 consecutive stall cycles, visiting LU_STALL with lu_cnt 2 then 1, then NORMAL.
- Masking: ex_rd=0 with src=0, or a match with src_used[i]=0 -> no stall.
- Redirect with im_stall:
  - br_ctrl=01 while im_stall=1 for 3 cycles -> flush in the redirect cycle.
  - KILL_FETCH holds instr_flush=1 through the cycle im_stall drops, then NORMAL.
- dm_stall=1 for 4 cycles during LU_STALL (LOAD_LAT=2) -> pipe_hold=1 and lu_cnt frozen; the remaining stall resumes afterwards; mem_stall_cnt=4 with HAZARD_PERF_EN.
- Reset mid-LU_STALL: rst_n pulled low asynchronously -> outputs take reset values immediately; after release, state=NORMAL and the counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: EX redirect select encoding, hazard FSM state encoding and the
// default register address width used by the hazard and forwarding logic.
package hazard_pkg;

  // Default register-file address width for RV32 (32 architectural regs).
  localparam int REG_AW_DEF = 5;

  // EX-stage redirect select. Encoding 2'b11 has no name; the controller
  // treats any non-PC4 value as a redirect.
  typedef enum logic [1:0] {
    PC4  = 2'b00,
    PCB  = 2'b01,
    PCJR = 2'b10
  } br_ctrl_e;

  typedef enum logic [1:0] {
    NORMAL     = 2'b00,
    LU_STALL   = 2'b01,
    KILL_FETCH = 2'b10
  } hz_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_match.sv
// Load-use hazard detector: flags an ID source that reads the EX load's rd.
// Latency: purely combinational, zero cycles.
// Backpressure: none; shared with the forwarding unit.
//
// Ports:
//   mem_read  in   EX instruction is a load
//   rd_addr   in   EX destination register (x0 never matches)
//   src_addr  in   packed ID source addresses, source i at [i*REG_AW +: REG_AW]
//   src_used  in   per-source valid mask
//   match     out  at least one valid source reads the loaded register
module hazard_match #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = hazard_pkg::REG_AW_DEF
) (
  input  logic                      mem_read,
  input  logic [REG_AW-1:0]         rd_addr,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  output logic                      match
);

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && (src_addr[i*REG_AW +: REG_AW] == rd_addr)) begin
        match = 1'b1;
      end
    end
    // x0 is hard-wired zero, so a load targeting it can never create a hazard.
    if (!mem_read || (rd_addr == '0)) begin
      match = 1'b0;
    end
  end

endmodule : hazard_match

// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller for the 5-stage RV32 core (load-use, redirect, mem waits).
// Latency: outputs combinational from registered state and current inputs.
// Backpressure: dm_stall freezes the back pipe, im_stall holds PC, load-use bubbles ID/EX.
//
// Ports:
//   clk, rst_n        core clock, asynchronous active-low reset
//   br_ctrl           EX redirect select (non-zero = redirect)
//   ex_mem_read       EX instruction is a load
//   ex_rd_addr        EX destination register
//   src_addr/src_used ID source addresses and valid mask
//   im_stall/dm_stall instruction fetch / data access not complete
//   pc_write          PC update enable
//   ifid_write        IF/ID enable
//   instr_flush       load NOP into IF/ID
//   id_flush          load NOP into ID/EX
//   pipe_hold         freeze ID/EX, EX/MEM, MEM/WB
//   *_cnt             performance counters
//
// Build option: define HAZARD_PERF_EN to enable the saturating performance
// counters; without it the counter ports read zero and no counter flops exist.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                br_ctrl,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         ex_rd_addr,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_used,
  input  logic                      im_stall,
  input  logic                      dm_stall,
  output logic                      pc_write,
  output logic                      ifid_write,
  output logic                      instr_flush,
  output logic                      id_flush,
  output logic                      pipe_hold,
  output logic [CNT_W-1:0]          lu_stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt,
  output logic [CNT_W-1:0]          mem_stall_cnt
);

  localparam int LU_W = $clog2(LOAD_LAT + 1);
  typedef logic [LU_W-1:0] lu_cnt_t;

  // The first bubble is issued from NORMAL, so LU_STALL covers the rest.
  localparam lu_cnt_t LU_INIT = lu_cnt_t'(LOAD_LAT - 1);
  localparam lu_cnt_t LU_ONE  = lu_cnt_t'(1);

  hz_state_e state_q, state_d;
  lu_cnt_t   lu_cnt_q, lu_cnt_d;
  logic      hz_match;
  logic      redirect;

  hazard_match #(
    .NUM_SRC (NUM_SRC),
    .REG_AW  (REG_AW)
  ) u_match (
    .mem_read (ex_mem_read),
    .rd_addr  (ex_rd_addr),
    .src_addr (src_addr),
    .src_used (src_used),
    .match    (hz_match)
  );

  // Encoding 2'b11 is not a legal select but is still treated as a redirect.
  assign redirect = (br_ctrl != PC4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      lu_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  // Priority chain: data-memory wait, redirect, fetch kill, load-use,
  // fetch wait, then normal advance.
  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    instr_flush = 1'b0;
    id_flush    = 1'b0;
    pipe_hold   = 1'b0;

    if (!rst_n) begin
      // Keep the front end quiet and bubbles flowing while held in reset.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      instr_flush = 1'b1;
      id_flush    = 1'b1;
    end else if (dm_stall) begin
      // Whole pipe frozen; FSM and bubble count resume where they left off.
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (redirect) begin
      // Wrong-path instructions in IF/ID and ID are squashed; any pending
      // load-use bubble is moot because the dependent instruction is gone.
      instr_flush = 1'b1;
      id_flush    = 1'b1;
      lu_cnt_d    = '0;
      // A fetch still in flight will return the wrong-path instruction, so
      // remember to discard it when it arrives.
      state_d     = im_stall ? KILL_FETCH : NORMAL;
    end else if (state_q == KILL_FETCH) begin
      instr_flush = 1'b1;
      pc_write    = !im_stall;
      // The returning stale instruction is flushed in this same cycle.
      if (!im_stall) begin
        state_d = NORMAL;
      end
    end else if ((state_q == LU_STALL) || hz_match) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      id_flush   = 1'b1;
      if (state_q == LU_STALL) begin
        if (lu_cnt_q <= LU_ONE) begin
          state_d  = NORMAL;
          lu_cnt_d = '0;
        end else begin
          lu_cnt_d = lu_cnt_q - LU_ONE;
        end
      end else if (LOAD_LAT > 1) begin
        state_d  = LU_STALL;
        lu_cnt_d = LU_INIT;
      end
    end else if (im_stall) begin
      // Hold PC, present a NOP to decode until the fetch completes.
      pc_write    = 1'b0;
      instr_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic             inc_lu, inc_flush, inc_mem;
  logic [CNT_W-1:0] lu_stall_cnt_q, lu_stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] mem_stall_cnt_q, mem_stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  // Event qualifiers mirror the priority chain above.
  always_comb begin
    inc_mem         = dm_stall;
    inc_flush       = !dm_stall && redirect;
    inc_lu          = !dm_stall && !redirect && (state_q != KILL_FETCH) &&
                      ((state_q == LU_STALL) || hz_match);
    lu_stall_cnt_d  = sat_inc(lu_stall_cnt_q, inc_lu);
    flush_cnt_d     = sat_inc(flush_cnt_q, inc_flush);
    mem_stall_cnt_d = sat_inc(mem_stall_cnt_q, inc_mem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt_q  <= '0;
      flush_cnt_q     <= '0;
      mem_stall_cnt_q <= '0;
    end else begin
      lu_stall_cnt_q  <= lu_stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
    end
  end

  assign lu_stall_cnt  = lu_stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign mem_stall_cnt = mem_stall_cnt_q;
`else
  assign lu_stall_cnt  = '0;
  assign flush_cnt     = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule : hazard_ctrl_mc

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: three instances (LOAD_LAT 1, 2, 3) share
// one stimulus stream; each step checks the control vector
// {pc_write, ifid_write, instr_flush, id_flush, pipe_hold} of every instance.
module tb_hazard_ctrl_mc;
  import hazard_pkg::*;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected control vectors {pc_write, ifid_write, instr_flush, id_flush, pipe_hold}
  localparam logic [4:0] O_NRM = 5'b11000;
  localparam logic [4:0] O_LUS = 5'b00010;
  localparam logic [4:0] O_IMS = 5'b01100;
  localparam logic [4:0] O_RED = 5'b11110;
  localparam logic [4:0] O_DMS = 5'b00001;
  localparam logic [4:0] O_RST = 5'b00110;
  localparam logic [4:0] O_KIM = 5'b01100;
  localparam logic [4:0] O_KOK = 5'b11100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  br_ctrl;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic [9:0]  src_addr;
  logic [1:0]  src_used;
  logic        im_stall;
  logic        dm_stall;

  logic        pw  [3];
  logic        iw  [3];
  logic        ifl [3];
  logic        idf [3];
  logic        ph  [3];
  logic [31:0] lc  [3];
  logic [31:0] fc  [3];
  logic [31:0] mc  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .br_ctrl(br_ctrl), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .src_addr(src_addr), .src_used(src_used),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(pw[0]),
    .ifid_write(iw[0]), .instr_flush(ifl[0]), .id_flush(idf[0]),
    .pipe_hold(ph[0]), .lu_stall_cnt(lc[0]), .flush_cnt(fc[0]),
    .mem_stall_cnt(mc[0]));

  hazard_ctrl_mc #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(2), .CNT_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .br_ctrl(br_ctrl), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .src_addr(src_addr), .src_used(src_used),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(pw[1]),
    .ifid_write(iw[1]), .instr_flush(ifl[1]), .id_flush(idf[1]),
    .pipe_hold(ph[1]), .lu_stall_cnt(lc[1]), .flush_cnt(fc[1]),
    .mem_stall_cnt(mc[1]));

  hazard_ctrl_mc #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .br_ctrl(br_ctrl), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .src_addr(src_addr), .src_used(src_used),
    .im_stall(im_stall), .dm_stall(dm_stall), .pc_write(pw[2]),
    .ifid_write(iw[2]), .instr_flush(ifl[2]), .id_flush(idf[2]),
    .pipe_hold(ph[2]), .lu_stall_cnt(lc[2]), .flush_cnt(fc[2]),
    .mem_stall_cnt(mc[2]));

  function automatic logic [4:0] outs(input int k);
    return {pw[k], iw[k], ifl[k], idf[k], ph[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e1,
                         input logic [4:0] e2, input logic [4:0] e3);
    chk({tag, "/lat1"}, {27'd0, outs(0)}, {27'd0, e1});
    chk({tag, "/lat2"}, {27'd0, outs(1)}, {27'd0, e2});
    chk({tag, "/lat3"}, {27'd0, outs(2)}, {27'd0, e3});
  endtask

  task automatic set_in(input logic [1:0] br, input logic mr, input logic [4:0] rd,
                        input logic [4:0] s1, input logic [4:0] s0,
                        input logic [1:0] used, input logic im, input logic dm);
    br_ctrl     = br;
    ex_mem_read = mr;
    ex_rd_addr  = rd;
    src_addr    = {s1, s0};
    src_used    = used;
    im_stall    = im;
    dm_stall    = dm;
  endtask

  task automatic idle();
    set_in(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    idle();
    #2;
    chk_all("reset_out", O_RST, O_RST, O_RST);
    chk("reset_state3", {30'd0, dut3.state_q}, {30'd0, NORMAL});
    chk("reset_lucnt3", {30'd0, dut3.lu_cnt_q}, 32'd0);
    chk("reset_mcnt", mc[0], 32'd0);
    #1 rst_n = 1'b1;
    #1;
    chk_all("idle", O_NRM, O_NRM, O_NRM);
    tick();

    // Load-use on source 0: LOAD_LAT bubbles per instance
    set_in(2'b00, 1'b1, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0);
    #1 chk_all("lu_c0", O_LUS, O_LUS, O_LUS);
    tick();
    idle();
    #1 chk_all("lu_c1", O_NRM, O_LUS, O_LUS);
    chk("lu_c1_st3", {30'd0, dut3.state_q}, {30'd0, LU_STALL});
    chk("lu_c1_cnt3", {30'd0, dut3.lu_cnt_q}, 32'd2);
    chk("lu_c1_cnt2", {30'd0, dut2.lu_cnt_q}, 32'd1);
    tick();
    #1 chk_all("lu_c2", O_NRM, O_NRM, O_LUS);
    chk("lu_c2_cnt3", {30'd0, dut3.lu_cnt_q}, 32'd1);
    tick();
    #1 chk_all("lu_c3", O_NRM, O_NRM, O_NRM);
    chk("lu_c3_st3", {30'd0, dut3.state_q}, {30'd0, NORMAL});
    tick();

    // Masking: x0 destination, unused source, non-load
    set_in(2'b00, 1'b1, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0);
    #1 chk_all("mask_x0", O_NRM, O_NRM, O_NRM);
    tick();
    set_in(2'b00, 1'b1, 5'd7, 5'd7, 5'd3, 2'b01, 1'b0, 1'b0);
    #1 chk_all("mask_unused", O_NRM, O_NRM, O_NRM);
    tick();
    set_in(2'b00, 1'b0, 5'd7, 5'd0, 5'd7, 2'b01, 1'b0, 1'b0);
    #1 chk_all("mask_noload", O_NRM, O_NRM, O_NRM);
    tick();

    // Load-use via source 1
    set_in(2'b00, 1'b1, 5'd7, 5'd7, 5'd0, 2'b10, 1'b0, 1'b0);
    #1 chk_all("src1_c0", O_LUS, O_LUS, O_LUS);
    tick();
    idle();
    #1 chk_all("src1_c1", O_NRM, O_LUS, O_LUS);
    tick();
    #1 chk_all("src1_c2", O_NRM, O_NRM, O_LUS);
    tick();
    #1 chk_all("src1_c3", O_NRM, O_NRM, O_NRM);
    tick();

    // Plain fetch wait
    set_in(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    #1 chk_all("im_wait", O_IMS, O_IMS, O_IMS);
    tick();

    // Redirect with fetch outstanding -> KILL_FETCH until im_stall drops
    set_in(2'b01, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    #1 chk_all("redir_im", O_RED, O_RED, O_RED);
    tick();
    chk("kill_state1", {30'd0, dut1.state_q}, {30'd0, KILL_FETCH});
    set_in(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
    #1 chk_all("kill_w1", O_KIM, O_KIM, O_KIM);
    tick();
    #1 chk_all("kill_w2", O_KIM, O_KIM, O_KIM);
    tick();
    im_stall = 1'b0;
    #1 chk_all("kill_drop", O_KOK, O_KOK, O_KOK);
    tick();
    #1 chk_all("kill_after", O_NRM, O_NRM, O_NRM);
    chk("kill_after_st1", {30'd0, dut1.state_q}, {30'd0, NORMAL});
    tick();

    // Hazard concurrent with im_stall takes the load-use response
    set_in(2'b00, 1'b1, 5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0);
    #1 chk_all("lu_im", O_LUS, O_LUS, O_LUS);
    tick();

    // Redirect aborts LU_STALL
    set_in(2'b10, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    #1 chk_all("redir_abort", O_RED, O_RED, O_RED);
    tick();
    chk("abort_st3", {30'd0, dut3.state_q}, {30'd0, NORMAL});
    chk("abort_cnt3", {30'd0, dut3.lu_cnt_q}, 32'd0);

    // br_ctrl=11 is a redirect; without im_stall it returns to NORMAL
    set_in(2'b11, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    #1 chk_all("redir_11", O_RED, O_RED, O_RED);
    tick();
    idle();
    #1 chk_all("redir_11_after", O_NRM, O_NRM, O_NRM);
    chk("redir_11_st1", {30'd0, dut1.state_q}, {30'd0, NORMAL});
    tick();

    // dm_stall during LU_STALL freezes state and lu_cnt
    set_in(2'b00, 1'b1, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0);
    #1 chk_all("dm_lu_c0", O_LUS, O_LUS, O_LUS);
    tick();
    set_in(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      #1 chk_all("dm_hold", O_DMS, O_DMS, O_DMS);
      chk("dm_hold_cnt2", {30'd0, dut2.lu_cnt_q}, 32'd1);
      chk("dm_hold_st2", {30'd0, dut2.state_q}, {30'd0, LU_STALL});
      tick();
    end
    idle();
    #1 chk_all("dm_resume1", O_NRM, O_LUS, O_LUS);
    chk("dm_resume_cnt3", {30'd0, dut3.lu_cnt_q}, 32'd2);
    tick();
    #1 chk_all("dm_resume2", O_NRM, O_NRM, O_LUS);
    tick();
    #1 chk_all("dm_resume3", O_NRM, O_NRM, O_NRM);

    // Counters: zero unless the perf option is built in
    chk("cnt_mem1", mc[0], PERF ? 32'd4 : 32'd0);
    chk("cnt_mem2", mc[1], PERF ? 32'd4 : 32'd0);
    chk("cnt_flush", fc[2], PERF ? 32'd3 : 32'd0);
    chk("cnt_lu1", lc[0], PERF ? 32'd4 : 32'd0);
    chk("cnt_lu2", lc[1], PERF ? 32'd7 : 32'd0);
    chk("cnt_lu3", lc[2], PERF ? 32'd10 : 32'd0);
    tick();

    // Asynchronous reset in the middle of LU_STALL
    set_in(2'b00, 1'b1, 5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0);
    #1 chk_all("rst_lu_c0", O_LUS, O_LUS, O_LUS);
    tick();
    idle();
    #1 rst_n = 1'b0;
    #1 chk_all("rst_mid", O_RST, O_RST, O_RST);
    chk("rst_mid_st3", {30'd0, dut3.state_q}, {30'd0, NORMAL});
    chk("rst_mid_cnt3", {30'd0, dut3.lu_cnt_q}, 32'd0);
    #1 rst_n = 1'b1;
    #1 chk_all("rst_rel", O_NRM, O_NRM, O_NRM);
    chk("rst_rel_lu3", lc[2], 32'd0);
    chk("rst_rel_flush", fc[0], 32'd0);
    chk("rst_rel_mem", mc[1], 32'd0);
    tick();
    #1 chk_all("rst_rel_next", O_NRM, O_NRM, O_NRM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_ctrl_mc
